dmem_arbiter: RTL
=================

# dmem_arbiter

Round-robin arbiter that shares the single-port data memory between the matrix-multiplication cores. Each core issues word read/write requests with a request/acknowledge handshake. The arbiter serialises them onto the memory port and returns read data and a one-cycle acknowledge to the winning core. It sits between the core array and the data memory, below the top-level START/END control.

## Interface

**Parameters**
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 16, data-memory address width
- DATA_W, 16, data word width
- CORE_ID_W, $clog2(NUM_CORES), width of grant index

**Ports**
- clk  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- core_dread  in  NUM_CORES  per-core read request, bit i = core i
- core_dwrite  in  NUM_CORES  per-core write request
- core_addr  in  NUM_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  per-core write data, same packing
- core_ack  out  NUM_CORES  one-hot acknowledge pulse, one cycle
- core_rdata  out  DATA_W  read data, shared by all cores, valid when the matching ack is high
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_read
- grant_id  out  CORE_ID_W  index of the core currently being served
- busy  out  1  high whenever state != IDLE

## Operation

- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - Request vector req[i] = core_dread[i] | core_dwrite[i].
  - If any bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_CORES.
  - Latch grant_id, address, write data and op (write when core_dwrite set; write wins if both read and write are set).
  - Go to ACCESS.
- **ACCESS:** drive mem_addr and mem_wdata from the latched values. Assert exactly one of mem_read/mem_write for this one cycle. Go to RESP.
- **RESP:**
  - Register mem_rdata into core_rdata (read only; on a write core_rdata holds its previous value).
  - Pulse core_ack[grant_id].
  - Set rr_ptr = (grant_id+1) mod NUM_CORES. Go to IDLE.
- Requester rules:
  - Hold request, address and data stable until it sees ack.
  - Drop the request in the cycle after ack. A request still high in the IDLE cycle after ack is treated as a new request.
- Address and data inputs of non-granted cores are ignored. Changes to the granted core's inputs after the IDLE latch edge have no effect.
- Fairness: a continuously requesting core waits at most NUM_CORES-1 transactions.

## Timing

- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0
  - core_ack=0, core_rdata=0
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0
- All outputs are registered.
- Latency from a request sampled in IDLE (edge E) to the ack:
  - mem strobe is high for the cycle after E.
  - core_ack is high for the cycle after that.
  - Throughput is one transaction per 3 cycles.
- mem_read and mem_write are never high together, and never high outside ACCESS.
- Simultaneous requests are resolved purely by rr_ptr. With equal priority after reset, core 0 wins.
- A request arriving during ACCESS/RESP waits for the next IDLE.
- RESET in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - Any in-flight strobe is dropped and the ack is suppressed.
  - rr_ptr returns to 0.
- rr_ptr wraps from NUM_CORES-1 to 0.

## Structure

- Shared package `mm_pkg` holds:
  - constants for ADDR_W and DATA_W
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
- One natural sub-module, `rr_priority_pick`: combinational round-robin picker taking (req, rr_ptr) and returning grant index and valid. It is reusable for the instruction-memory port.
- The FSM and datapath registers stay in dmem_arbiter.

## Test plan

- **Single read:** after RESET, core 2 raises dread with addr 0x0010; memory returns 0x1234.
  - mem_read is high for one cycle with mem_addr=0x0010.
  - Two cycles after the request edge, core_ack=4'b0100 and core_rdata=0x1234.
  - busy is high for 2 cycles.
- **Single write:** core 1 writes 0xBEEF to 0x0005.
  - One mem_write pulse with addr 0x0005 and data 0xBEEF, no mem_read.
  - core_ack=4'b0010.
  - core_rdata unchanged.
- **All four cores request continuously from reset:** grant order is 0,1,2,3,0.
  - Acks are spaced exactly 3 cycles apart.
  - mem_read and mem_write are never both high.
- **Fairness after partial service:** core 3 served (rr_ptr=0), then cores 1 and 3 request together.
  - Core 1 is granted first, then core 3.
- **Read and write both set on core 0:** treated as a write.
  - mem_write=1, mem_read=0.
- **RESET asserted during ACCESS of a core 2 read:**
  - No core_ack is produced.
  - Next cycle all outputs are at reset values and busy=0.
  - A new core 3 request is then served normally.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplication memory subsystem:
// memory word/address widths and the arbiter state encoding.
package mm_pkg;

  localparam int MM_ADDR_W = 16;
  localparam int MM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arbState_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// searching upward from ptr_i, wrapping modulo NUM_CORES. Shared by the data
// and instruction memory arbiters.
module rr_priority_pick #(
  parameter int NUM_CORES = 4,
  parameter int CORE_ID_W = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [CORE_ID_W-1:0] ptr_i,
  output logic [CORE_ID_W-1:0] grant_o,
  output logic                 valid_o
);

  // Walk the request vector starting at the pointer; the first hit wins.
  always_comb begin
    int                   cand;
    logic [CORE_ID_W-1:0] candId;
    cand    = 0;
    candId  = '0;
    grant_o = '0;
    valid_o = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_CORES) begin
        cand = cand - NUM_CORES;
      end
      candId = CORE_ID_W'(cand);
      if (!valid_o && req_i[candId]) begin
        valid_o = 1'b1;
        grant_o = candId;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising core word read/write requests onto the
// single-port data memory. Each transaction takes three cycles: IDLE (pick and
// latch), ACCESS (one memory strobe), RESP (one-cycle ack to the winner).
module dmem_arbiter
  import mm_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = MM_ADDR_W,
  parameter int DATA_W    = MM_DATA_W,
  parameter int CORE_ID_W = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic [NUM_CORES-1:0]        core_dread,
  input  logic [NUM_CORES-1:0]        core_dwrite,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_read,
  output logic                        mem_write,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [CORE_ID_W-1:0]        grant_id,
  output logic                        busy
);

  arbState_e            state_q, state_d;
  logic [CORE_ID_W-1:0] rrPtr_q, rrPtr_d;
  logic [CORE_ID_W-1:0] grantId_q, grantId_d;
  logic                 isWrite_q, isWrite_d;
  logic                 memRead_q, memRead_d;
  logic                 memWrite_q, memWrite_d;
  logic                 busy_q, busy_d;
  logic [ADDR_W-1:0]    memAddr_q, memAddr_d;
  logic [DATA_W-1:0]    memWdata_q, memWdata_d;
  logic [DATA_W-1:0]    coreRdata_q, coreRdata_d;
  logic [NUM_CORES-1:0] coreAck_q, coreAck_d;

  logic [NUM_CORES-1:0] req;
  logic [CORE_ID_W-1:0] pickId;
  logic                 pickValid;
  logic [ADDR_W-1:0]    selAddr;
  logic [DATA_W-1:0]    selWdata;
  logic                 selWrite;

  assign req      = core_dread | core_dwrite;
  assign selAddr  = core_addr[pickId*ADDR_W +: ADDR_W];
  assign selWdata = core_wdata[pickId*DATA_W +: DATA_W];
  // A core raising both read and write is served as a write.
  assign selWrite = core_dwrite[pickId];

  rr_priority_pick #(
    .NUM_CORES (NUM_CORES),
    .CORE_ID_W (CORE_ID_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (rrPtr_q),
    .grant_o (pickId),
    .valid_o (pickValid)
  );

  // Next-state and registered-output logic; strobe and ack default low so
  // each is a single-cycle pulse.
  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    grantId_d   = grantId_q;
    isWrite_d   = isWrite_q;
    memRead_d   = 1'b0;
    memWrite_d  = 1'b0;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    coreRdata_d = coreRdata_q;
    coreAck_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d    = ACCESS;
          grantId_d  = pickId;
          isWrite_d  = selWrite;
          memAddr_d  = selAddr;
          memWdata_d = selWdata;
          memRead_d  = !selWrite;
          memWrite_d = selWrite;
        end
      end
      ACCESS: begin
        state_d              = RESP;
        coreAck_d[grantId_q] = 1'b1;
        if (!isWrite_q) begin
          coreRdata_d = mem_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (grantId_q == CORE_ID_W'(NUM_CORES - 1)) begin
          rrPtr_d = '0;
        end else begin
          rrPtr_d = grantId_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      grantId_q   <= '0;
      isWrite_q   <= 1'b0;
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      busy_q      <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      coreRdata_q <= '0;
      coreAck_q   <= '0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      grantId_q   <= grantId_d;
      isWrite_q   <= isWrite_d;
      memRead_q   <= memRead_d;
      memWrite_q  <= memWrite_d;
      busy_q      <= busy_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      coreRdata_q <= coreRdata_d;
      coreAck_q   <= coreAck_d;
    end
  end

  assign core_ack   = coreAck_q;
  assign core_rdata = coreRdata_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;
  assign mem_read   = memRead_q;
  assign mem_write  = memWrite_q;
  assign grant_id   = grantId_q;
  assign busy       = busy_q;

endmodule
